// File: rtl/mac_lut_table_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mac_lut_table_pkg : shared widths, entry layout and handshake FSM encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
package mac_lut_table_pkg;

  localparam int NOQ_DEF = 5;
  localparam int LDB_DEF = 4;
  localparam int MAC_W   = 48;

  // Entry layout is {protect, oq, mac}
  localparam int ENTRY_W = 1 + NOQ_DEF + MAC_W;

  function automatic int entry_w(input int noq);
    return 1 + noq + MAC_W;
  endfunction

  typedef enum logic [0:0] {
    HS_IDLE = 1'b0,
    HS_ACK  = 1'b1
  } hs_state_t;

endpackage
`default_nettype wire

// File: rtl/mac_lut_table_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mac_lut_table_if : register read/write handshake and lookup request/result
// Revision: 1.0
// ---------------------------------------------------------------------------
interface mac_lut_table_if #(
  parameter int NOQ = 5,
  parameter int LDB = 4
);
  logic [LDB-1:0] rd_addr;
  logic           rd_req;
  logic [NOQ-1:0] rd_oq;
  logic           rd_wr_protect;
  logic [47:0]    rd_mac;
  logic           rd_ack;

  logic [LDB-1:0] wr_addr;
  logic           wr_req;
  logic [NOQ-1:0] wr_oq;
  logic           wr_protect;
  logic [47:0]    wr_mac;
  logic           wr_ack;

  logic           lookup_req;
  logic [47:0]    lookup_dst_mac;
  logic [47:0]    lookup_src_mac;
  logic [NOQ-1:0] lookup_src_oq;
  logic           lookup_done;
  logic [NOQ-1:0] lookup_oq;
  logic           lut_hit;
  logic           lut_miss;

  modport master (
    output rd_addr, rd_req, wr_addr, wr_req, wr_oq, wr_protect, wr_mac,
           lookup_req, lookup_dst_mac, lookup_src_mac, lookup_src_oq,
    input  rd_oq, rd_wr_protect, rd_mac, rd_ack, wr_ack,
           lookup_done, lookup_oq, lut_hit, lut_miss
  );

  modport slave (
    input  rd_addr, rd_req, wr_addr, wr_req, wr_oq, wr_protect, wr_mac,
           lookup_req, lookup_dst_mac, lookup_src_mac, lookup_src_oq,
    output rd_oq, rd_wr_protect, rd_mac, rd_ack, wr_ack,
           lookup_done, lookup_oq, lut_hit, lut_miss
  );
endinterface
`default_nettype wire

// File: rtl/mac_lut_table_cam_match.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mac_lut_cam_match : valid-masked parallel MAC compare, lowest index wins
// Revision: 1.0
// ---------------------------------------------------------------------------
module mac_lut_cam_match #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic [DEPTH-1:0]       valid,
  input  logic [DEPTH-1:0][47:0] macs,
  input  logic [47:0]            key,
  output logic                   hit,
  output logic [IDX_W-1:0]       idx
);

  logic [DEPTH-1:0] match;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
      assign match[i] = valid[i] && (macs[i] == key);
    end
  endgenerate

  // Scan downward so the lowest matching index is the last assignment
  always_comb begin
    hit = |match;
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) idx = IDX_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mac_lut_table.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mac_lut_table : output-port MAC table with register access, lookup, learning
// Revision: 1.0
// ---------------------------------------------------------------------------
module mac_lut_table
  import mac_lut_table_pkg::*;
#(
  parameter int NUM_OUTPUT_QUEUES = NOQ_DEF,
  parameter int LUT_DEPTH_BITS    = LDB_DEF
) (
  input  logic           clk,
  input  logic           reset,
  mac_lut_table_if.slave bus
);

  localparam int NOQ   = NUM_OUTPUT_QUEUES;
  localparam int LDB   = LUT_DEPTH_BITS;
  localparam int DEPTH = 1 << LDB;
  localparam int EW    = entry_w(NOQ);

  logic [DEPTH-1:0]            tbl_prot;
  logic [DEPTH-1:0][NOQ-1:0]   tbl_oq;
  logic [DEPTH-1:0][MAC_W-1:0] tbl_mac;
  logic [DEPTH-1:0]            tbl_valid;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_valid
      assign tbl_valid[i] = |tbl_oq[i];
    end
  endgenerate

  // Register read handshake
  hs_state_t      rd_state, rd_state_nx;
  logic           rd_load;
  logic [EW-1:0]  rd_entry;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_state <= HS_IDLE;
    else       rd_state <= rd_state_nx;
  end

  always_comb begin
    rd_state_nx = rd_state;
    rd_load     = 1'b0;
    case (rd_state)
      HS_IDLE: if (bus.rd_req) begin
        rd_load     = 1'b1;
        rd_state_nx = HS_ACK;
      end
      HS_ACK:  if (!bus.rd_req) rd_state_nx = HS_IDLE;
      default: rd_state_nx = HS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        rd_entry <= '0;
    else if (rd_load) rd_entry <= {tbl_prot[bus.rd_addr], tbl_oq[bus.rd_addr], tbl_mac[bus.rd_addr]};
  end

  assign bus.rd_ack        = (rd_state == HS_ACK);
  assign bus.rd_wr_protect = rd_entry[EW-1];
  assign bus.rd_oq         = rd_entry[MAC_W +: NOQ];
  assign bus.rd_mac        = rd_entry[MAC_W-1:0];

  // Register write handshake: the table is written only on the IDLE->ACK edge
  hs_state_t wr_state, wr_state_nx;
  logic      wr_fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr_state <= HS_IDLE;
    else       wr_state <= wr_state_nx;
  end

  always_comb begin
    wr_state_nx = wr_state;
    wr_fire     = 1'b0;
    case (wr_state)
      HS_IDLE: if (bus.wr_req) begin
        wr_fire     = 1'b1;
        wr_state_nx = HS_ACK;
      end
      HS_ACK:  if (!bus.wr_req) wr_state_nx = HS_IDLE;
      default: wr_state_nx = HS_IDLE;
    endcase
  end

  assign bus.wr_ack = (wr_state == HS_ACK);

  // Lookup stage 1: capture request
  logic             s1_valid;
  logic [MAC_W-1:0] s1_dst, s1_src;
  logic [NOQ-1:0]   s1_src_oq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_dst    <= '0;
      s1_src    <= '0;
      s1_src_oq <= '0;
    end else begin
      s1_valid <= bus.lookup_req;
      if (bus.lookup_req) begin
        s1_dst    <= bus.lookup_dst_mac;
        s1_src    <= bus.lookup_src_mac;
        s1_src_oq <= bus.lookup_src_oq;
      end
    end
  end

  logic           dst_hit, src_hit;
  logic [LDB-1:0] dst_idx, src_idx;

  mac_lut_cam_match #(.DEPTH(DEPTH), .IDX_W(LDB)) u_dst_cam (
    .valid(tbl_valid), .macs(tbl_mac), .key(s1_dst), .hit(dst_hit), .idx(dst_idx)
  );

  mac_lut_cam_match #(.DEPTH(DEPTH), .IDX_W(LDB)) u_src_cam (
    .valid(tbl_valid), .macs(tbl_mac), .key(s1_src), .hit(src_hit), .idx(src_idx)
  );

  // Source learning decision
  logic [LDB-1:0] victim;
  logic           learn_we, victim_adv;
  logic [LDB-1:0] learn_idx;

  always_comb begin
    learn_we   = 1'b0;
    victim_adv = 1'b0;
    learn_idx  = src_idx;
    if (s1_valid && (|s1_src_oq) && (|s1_src)) begin
      if (src_hit) begin
        learn_we = !tbl_prot[src_idx] && (tbl_oq[src_idx] != s1_src_oq);
      end else begin
        learn_idx  = victim;
        learn_we   = !tbl_prot[victim];
        victim_adv = 1'b1;
      end
    end
    // Flop array: only a collision on the same entry forces the learn to yield
    if (wr_fire && (bus.wr_addr == learn_idx)) learn_we = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           victim <= '0;
    else if (victim_adv) victim <= victim + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tbl_prot <= '0;
      tbl_oq   <= '0;
      tbl_mac  <= '0;
    end else begin
      if (learn_we) begin
        tbl_prot[learn_idx] <= 1'b0;
        tbl_oq[learn_idx]   <= s1_src_oq;
        tbl_mac[learn_idx]  <= s1_src;
      end
      if (wr_fire) begin
        tbl_prot[bus.wr_addr] <= bus.wr_protect;
        tbl_oq[bus.wr_addr]   <= bus.wr_oq;
        tbl_mac[bus.wr_addr]  <= bus.wr_mac;
      end
    end
  end

  // Lookup stage 2: registered result
  logic           done_q, hit_q, miss_q;
  logic [NOQ-1:0] oq_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      oq_q   <= '0;
    end else begin
      done_q <= s1_valid;
      hit_q  <= s1_valid && dst_hit;
      miss_q <= s1_valid && !dst_hit;
      if (s1_valid) oq_q <= dst_hit ? (tbl_oq[dst_idx] & ~s1_src_oq) : ~s1_src_oq;
    end
  end

  assign bus.lookup_done = done_q;
  assign bus.lut_hit     = hit_q;
  assign bus.lut_miss    = miss_q;
  assign bus.lookup_oq   = oq_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_lut_table.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mac_lut_table : directed self-checking bench for mac_lut_table
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mac_lut_table;

  localparam int NOQ = 5;
  localparam int LDB = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_lut_table_if #(.NOQ(NOQ), .LDB(LDB)) bus ();

  mac_lut_table #(.NUM_OUTPUT_QUEUES(NOQ), .LUT_DEPTH_BITS(LDB)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [47:0] dst;
    logic [47:0] src;
    logic [4:0]  src_oq;
    logic [4:0]  exp_oq;
    logic        exp_hit;
  } lk_vec_t;

  lk_vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input string name, input logic [3:0] addr, input logic prot,
                          input logic [4:0] oq, input logic [47:0] mac);
    bus.wr_req = 1'b1; bus.wr_addr = addr; bus.wr_protect = prot; bus.wr_oq = oq; bus.wr_mac = mac;
    tick();
    check({name, " wr_ack rise"}, 64'(bus.wr_ack), 64'd1);
    bus.wr_mac = 48'hBAD0_BAD0_BAD0;
    bus.wr_oq  = 5'b11111;
    tick();
    check({name, " wr_ack held"}, 64'(bus.wr_ack), 64'd1);
    bus.wr_req = 1'b0;
    tick();
    check({name, " wr_ack drop"}, 64'(bus.wr_ack), 64'd0);
  endtask

  task automatic do_read(input string name, input logic [3:0] addr, input logic prot,
                         input logic [4:0] oq, input logic [47:0] mac);
    bus.rd_req = 1'b1; bus.rd_addr = addr;
    tick();
    check({name, " rd_ack"}, 64'(bus.rd_ack), 64'd1);
    check({name, " rd_prot"}, 64'(bus.rd_wr_protect), 64'(prot));
    check({name, " rd_oq"}, 64'(bus.rd_oq), 64'(oq));
    check({name, " rd_mac"}, 64'(bus.rd_mac), 64'(mac));
    bus.rd_addr = addr + 4'd1;
    tick();
    check({name, " rd_ack held"}, 64'(bus.rd_ack), 64'd1);
    check({name, " rd_mac held"}, 64'(bus.rd_mac), 64'(mac));
    bus.rd_req = 1'b0;
    tick();
    check({name, " rd_ack drop"}, 64'(bus.rd_ack), 64'd0);
  endtask

  task automatic do_lookup(input string name, input logic [47:0] dst, input logic [47:0] src,
                           input logic [4:0] src_oq, input logic [4:0] exp_oq, input logic exp_hit);
    bus.lookup_req = 1'b1; bus.lookup_dst_mac = dst; bus.lookup_src_mac = src; bus.lookup_src_oq = src_oq;
    tick();
    bus.lookup_req = 1'b0;
    check({name, " done early"}, 64'(bus.lookup_done), 64'd0);
    tick();
    check({name, " done"}, 64'(bus.lookup_done), 64'd1);
    check({name, " oq"}, 64'(bus.lookup_oq), 64'(exp_oq));
    check({name, " hit/miss"}, 64'({bus.lut_hit, bus.lut_miss}), 64'({exp_hit, !exp_hit}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{48'h001122334455, 48'h0,            5'b00001, 5'b00100, 1'b1};
    vecs[1]  = '{48'hDEADBEEF0000, 48'hAA0000000001, 5'b00010, 5'b11101, 1'b0};
    vecs[2]  = '{48'hAA0000000001, 48'h0,            5'b00001, 5'b00010, 1'b1};
    vecs[3]  = '{48'hAA0000000001, 48'h0,            5'b00010, 5'b00000, 1'b1};
    vecs[4]  = '{48'h000000000123, 48'hBB0000000002, 5'b01000, 5'b10111, 1'b0};
    vecs[5]  = '{48'hBB0000000002, 48'hCC0000000003, 5'b10000, 5'b01000, 1'b1};
    vecs[6]  = '{48'hCC0000000003, 48'hDD0000000004, 5'b00001, 5'b10000, 1'b1};
    vecs[7]  = '{48'hDD0000000004, 48'hEE0000000005, 5'b00100, 5'b11011, 1'b0};
    vecs[8]  = '{48'h000000000000, 48'h0,            5'b00001, 5'b11110, 1'b0};
    vecs[9]  = '{48'hEE0000000005, 48'hAA0000000001, 5'b00100, 5'b00000, 1'b1};
    vecs[10] = '{48'hAA0000000001, 48'h0,            5'b00001, 5'b00100, 1'b1};
    vecs[11] = '{48'h000000000777, 48'h001122334455, 5'b00001, 5'b11110, 1'b0};
    vecs[12] = '{48'h001122334455, 48'h0,            5'b00010, 5'b00100, 1'b1};

    bus.rd_req = 0; bus.rd_addr = 0;
    bus.wr_req = 0; bus.wr_addr = 0; bus.wr_oq = 0; bus.wr_protect = 0; bus.wr_mac = 0;
    bus.lookup_req = 0; bus.lookup_dst_mac = 0; bus.lookup_src_mac = 0; bus.lookup_src_oq = 0;

    reset = 1'b1;
    tick(); tick();
    check("reset rd_ack", 64'(bus.rd_ack), 64'd0);
    check("reset wr_ack", 64'(bus.wr_ack), 64'd0);
    check("reset done", 64'(bus.lookup_done), 64'd0);
    check("reset oq", 64'(bus.lookup_oq), 64'd0);
    check("reset hit/miss", 64'({bus.lut_hit, bus.lut_miss}), 64'd0);
    reset = 1'b0;
    tick();

    do_write("wr idx3", 4'd3, 1'b1, 5'b00100, 48'h001122334455);
    do_read("rd idx3", 4'd3, 1'b1, 5'b00100, 48'h001122334455);

    for (int i = 0; i < 13; i++) begin
      do_lookup($sformatf("lookup[%0d]", i), vecs[i].dst, vecs[i].src, vecs[i].src_oq,
                vecs[i].exp_oq, vecs[i].exp_hit);
    end

    // Learned entries: victim skipped protected idx3, so EE landed in idx4
    do_read("rd idx4 learned", 4'd4, 1'b0, 5'b00100, 48'hEE0000000005);
    do_read("rd idx0 moved", 4'd0, 1'b0, 5'b00100, 48'hAA0000000001);

    // Learn (victim idx5) collides with a register write to idx5
    bus.lookup_req = 1'b1; bus.lookup_dst_mac = 48'h000000000999;
    bus.lookup_src_mac = 48'hFF0000000006; bus.lookup_src_oq = 5'b00001;
    tick();
    bus.lookup_req = 1'b0;
    bus.wr_req = 1'b1; bus.wr_addr = 4'd5; bus.wr_protect = 1'b0;
    bus.wr_oq = 5'b10000; bus.wr_mac = 48'h121212121212;
    tick();
    check("conflict done", 64'(bus.lookup_done), 64'd1);
    check("conflict miss", 64'(bus.lut_miss), 64'd1);
    check("conflict oq", 64'(bus.lookup_oq), 64'(5'b11110));
    check("conflict wr_ack", 64'(bus.wr_ack), 64'd1);
    bus.wr_req = 1'b0;
    tick();
    do_read("rd idx5 conflict", 4'd5, 1'b0, 5'b10000, 48'h121212121212);

    // Pointer advanced past the dropped learn
    do_lookup("learn idx6", 48'h000000000888, 48'h990000000007, 5'b00010, 5'b11101, 1'b0);
    do_read("rd idx6", 4'd6, 1'b0, 5'b00010, 48'h990000000007);

    // Duplicate MAC at a higher index: lowest index wins
    do_write("wr idx7 dup", 4'd7, 1'b0, 5'b00010, 48'hBB0000000002);
    do_lookup("dup lowest", 48'hBB0000000002, 48'h0, 5'b00001, 5'b01000, 1'b1);

    // Back-to-back lookups
    bus.lookup_req = 1'b1; bus.lookup_dst_mac = 48'h001122334455;
    bus.lookup_src_mac = 48'h0; bus.lookup_src_oq = 5'b00001;
    tick();
    bus.lookup_dst_mac = 48'h000000000abc;
    tick();
    bus.lookup_req = 1'b0;
    check("b2b first done", 64'(bus.lookup_done), 64'd1);
    check("b2b first", 64'({bus.lut_hit, bus.lookup_oq}), 64'({1'b1, 5'b00100}));
    tick();
    check("b2b second done", 64'(bus.lookup_done), 64'd1);
    check("b2b second", 64'({bus.lut_miss, bus.lookup_oq}), 64'({1'b1, 5'b11110}));
    tick();

    // Reset with a read acked and two lookups in flight
    bus.rd_req = 1'b1; bus.rd_addr = 4'd3;
    tick();
    check("pre-reset rd_ack", 64'(bus.rd_ack), 64'd1);
    bus.lookup_req = 1'b1; bus.lookup_dst_mac = 48'h001122334455;
    bus.lookup_src_mac = 48'h0; bus.lookup_src_oq = 5'b00001;
    tick();
    bus.lookup_dst_mac = 48'h000000000def;
    tick();
    bus.lookup_req = 1'b0;
    check("pre-reset hit", 64'(bus.lut_hit), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async rd_ack", 64'(bus.rd_ack), 64'd0);
    check("async done", 64'(bus.lookup_done), 64'd0);
    check("async hit/miss", 64'({bus.lut_hit, bus.lut_miss}), 64'd0);
    bus.rd_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("post-reset done", 64'(bus.lookup_done), 64'd0);
    do_read("rd idx3 cleared", 4'd3, 1'b0, 5'b00000, 48'h0);
    do_lookup("post-reset lookup", 48'h001122334455, 48'h0, 5'b00001, 5'b11110, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
